gate_array_pipe: RTL and testbench

GATE_ARRAY_PIPE -- requirements
Module: gate_array_pipe

---
 rtl/gate_array_pkg.sv | 16 +
 rtl/gate_pipe_stage.sv | 39 +++
 rtl/gate_array_pipe.sv | 86 ++++++++
 tb/tb_gate_array_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_array_pkg.sv
// Shared definitions for gate_array_pipe: op encoding and width constants.
package gate_array_pkg;
  localparam int OP_W  = 3;
  localparam int CNT_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NAND = 3'd0,
    OP_NOR  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } gate_op_e;
endpackage

// File: rtl/gate_pipe_stage.sv
// One elastic register slot: loads when empty or when its contents leave this cycle.
module gate_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/gate_array_pipe.sv
// Two-stage elastic bitwise-gate pipeline: S1 holds operands, S2 holds the result.
// Optional transaction counter enabled by GATE_ARRAY_PIPE_STATS_EN.
module gate_array_pipe
  import gate_array_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [OP_W-1:0]  out_op,
  output logic [CNT_W-1:0] txn_count
);
  localparam int P1 = 2*WIDTH + OP_W;
  localparam int P2 = WIDTH + OP_W;

  logic             s1_valid, s2_ready;
  logic [P1-1:0]    s1_data;
  logic [WIDTH-1:0] s1_a, s1_b, c_d;
  logic [OP_W-1:0]  s1_op;

  gate_pipe_stage #(.W(P1)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({a, b, op}),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_data)
  );

  assign {s1_a, s1_b, s1_op} = s1_data;

  always_comb begin
    c_d = '0;
    unique case (gate_op_e'(s1_op))
      OP_NAND: c_d = ~(s1_a & s1_b);
      OP_NOR:  c_d = ~(s1_a | s1_b);
      OP_AND:  c_d = s1_a & s1_b;
      OP_OR:   c_d = s1_a | s1_b;
      OP_XOR:  c_d = s1_a ^ s1_b;
      OP_XNOR: c_d = ~(s1_a ^ s1_b);
      OP_NOTA: c_d = ~s1_a;
      OP_PASS: c_d = s1_a;
      default: c_d = '0;
    endcase
  end

  gate_pipe_stage #(.W(P2)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  ({c_d, s1_op}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data ({c, out_op})
  );

`ifdef GATE_ARRAY_PIPE_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates rather than wrapping so a long run never reads as a short one.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign txn_count = cnt_q;
`else
  assign txn_count = '0;
`endif
endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed + random bench for gate_array_pipe (WIDTH=8 and WIDTH=1 instances side by side).
module tb_gate_array_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [2:0]  op = '0;
  logic        in_ready, out_valid, in_ready1, out_valid1;
  logic [7:0]  c;
  logic [0:0]  c1;
  logic [2:0]  out_op, out_op1;
  logic [15:0] txn_count, txn_count1;

  always #5 clk = ~clk;

  gate_array_pipe #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .out_op(out_op), .txn_count(txn_count));

  gate_array_pipe #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a[0:0]), .b(b[0:0]), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
    .c(c1), .out_op(out_op1), .txn_count(txn_count1));

  typedef struct {
    logic [7:0] c8;
    logic       c1;
    logic [2:0] op;
    int         t;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0, nfail = 0, cyc = 0, nout = 0, cnt = 0;
  bit   acc, lat_chk = 0;
  logic [7:0] pend_c8;
  logic       pend_c1;

  // Reference gate function from the op table, on a 64-bit word.
  function automatic logic [63:0] ref_gate(logic [63:0] x, logic [63:0] y, int o);
    case (o)
      0: return ~(x & y);
      1: return ~(x | y);
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return ~(x ^ y);
      6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample mid-low-phase, score transfers, advance to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      nout++;
      if (q.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        e = q.pop_front();
        check("c", c, e.c8);
        check("out_op", out_op, e.op);
        check("c_w1", c1, e.c1);
        check("out_valid_w1", out_valid1, 1);
        if (lat_chk) check("latency", cyc - e.t, 2);
      end
      if (cnt < 16'hFFFF) cnt++;
    end
    if (acc) begin
      e.c8 = pend_c8; e.c1 = pend_c1; e.op = op; e.t = cyc;
      q.push_back(e);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_beat(logic [7:0] ta, logic [7:0] tb, logic [2:0] top);
    logic [63:0] r;
    a = ta; b = tb; op = top;
    r = ref_gate({56'd0, ta}, {56'd0, tb}, int'(top));
    pend_c8 = r[7:0];
    pend_c1 = r[0];
  endtask

  task automatic send_beat();
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [7:0] tbl [8];
    logic [7:0] hold;
    int n0;
    tbl = '{8'h3F, 8'h03, 8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

    // reset state
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_c", c, 0);
    check("rst_txn", txn_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // truth sweep, back-to-back, table expectations
    out_ready = 1'b1; lat_chk = 1; n0 = nout;
    for (int i = 0; i < 8; i++) begin
      set_beat(8'hF0, 8'hCC, 3'(i));
      pend_c8 = tbl[i];
      send_beat();
      in_valid = 1'b1;
    end
    in_valid = 1'b0;
    drain();
    lat_chk = 0;
    check("sweep_count", nout - n0, 8);

    // backpressure
    out_ready = 1'b0; n0 = nout;
    set_beat(8'h5A, 8'h33, 3'd4); send_beat();
    set_beat(8'hA5, 8'h0F, 3'd2); send_beat();
    set_beat(8'h81, 8'h7E, 3'd1);
    in_valid = 1'b1;
    tick();
    check("bp_third_blocked", acc, 0);
    hold = c;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_c_hold", c, hold);
      check("bp_valid_hold", out_valid, 1);
    end
    out_ready = 1'b1;
    send_beat();
    drain();
    check("bp_count", nout - n0, 3);

    // full-pipe streaming
    out_ready = 1'b0;
    set_beat(8'h11, 8'h22, 3'd3); send_beat();
    set_beat(8'h33, 8'h44, 3'd5); send_beat();
    out_ready = 1'b1; in_valid = 1'b1; n0 = nout;
    for (int k = 0; k < 10; k++) begin
      set_beat(8'($urandom), 8'($urandom), 3'($urandom));
      #1;
      check("stream_in_ready", in_ready, 1);
      check("stream_out_valid", out_valid, 1);
      tick();
    end
    in_valid = 1'b0;
    check("stream_count", nout - n0, 10);
    drain();

    // random traffic
    for (int k = 0; k < 60; k++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      set_beat(8'($urandom), 8'($urandom), 3'($urandom));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // mid-flight reset
    out_ready = 1'b0;
    set_beat(8'hDE, 8'hAD, 3'd0); send_beat();
    set_beat(8'hBE, 8'hEF, 3'd7); send_beat();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_c", c, 0);
    check("mid_rst_out_op", out_op, 0);
    check("mid_rst_txn", txn_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    q.delete(); cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check("mid_rst_no_ghost", out_valid, 0);
      tick();
    end

    // statistics
    for (int k = 0; k < 5; k++) begin
      set_beat(8'($urandom), 8'($urandom), 3'($urandom));
      send_beat();
    end
    drain();
`ifdef GATE_ARRAY_PIPE_STATS_EN
    check("txn_5", txn_count, 5);
    set_beat(8'h0F, 8'h3C, 3'd4);
    in_valid = 1'b1;
    for (int k = 0; k < 70000 && (cnt + q.size()) < 16'hFFFE; k++) tick();
    in_valid = 1'b0;
    drain();
    check("txn_fffe", txn_count, 16'hFFFE);
    for (int k = 0; k < 3; k++) send_beat();
    drain();
    check("txn_sat", txn_count, 16'hFFFF);
`else
    check("txn_tied0", txn_count, 0);
`endif

    // WIDTH=1 corner: op 0 over all a/b combinations
    for (int i = 0; i < 4; i++) begin
      set_beat(8'(i >> 1), 8'(i & 1), 3'd0);
      pend_c1 = (i == 3) ? 1'b0 : 1'b1;
      send_beat();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
